// File: rtl/digit_group_count.sv
`default_nettype none
// ============================================================================
// Module      : digit_group_count
// Description : Counts integers in [1, n_in] whose decimal form is one digit
//               block repeated exactly GROUP_N times. Also exposes the
//               decimal digit count of n_in combinationally.
//               Optional macro SUM_OUT_EN adds the sum_out port and the
//               running sum of the qualifying integers.
// Revision    : 1.0 - initial release
// ============================================================================
module digit_group_count #(
  parameter int DATA_WIDTH      = 32,
  parameter int LONG_DATA_WIDTH = 64,
  parameter int GROUP_N         = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      n_in,
  output logic [DATA_WIDTH-1:0]      digs_out,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [LONG_DATA_WIDTH-1:0] count_out
`ifdef SUM_OUT_EN
  ,
  output logic [LONG_DATA_WIDTH-1:0] sum_out
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_BLOCK = 3'd2;
  localparam logic [2:0] S_TRUNC = 3'd3;
  localparam logic [2:0] S_FINAL = 3'd4;

  // Smallest d >= 1 with n < 10^d. 10^19 still fits in 64 bits, which
  // covers any n of up to 64 bits; the overflowing final product is unused.
  function automatic logic [DATA_WIDTH-1:0] get_digs(input logic [DATA_WIDTH-1:0] n);
    logic [LONG_DATA_WIDTH-1:0] pw;
    logic [DATA_WIDTH-1:0]      d;
    d  = DATA_WIDTH'(1);
    pw = LONG_DATA_WIDTH'(10);
    for (int i = 2; i <= 20; i++) begin
      if (LONG_DATA_WIDTH'(n) >= pw) d = DATA_WIDTH'(i);
      pw = pw * LONG_DATA_WIDTH'(10);
    end
    return d;
  endfunction

  // Multiplier M = sum_{i<GROUP_N} (10^k)^i, so that block*M is the repeat.
  function automatic logic [LONG_DATA_WIDTH-1:0] rep_mult(input logic [LONG_DATA_WIDTH-1:0] p10);
    logic [LONG_DATA_WIDTH-1:0] m;
    logic [LONG_DATA_WIDTH-1:0] t;
    m = '0;
    t = LONG_DATA_WIDTH'(1);
    for (int i = 0; i < GROUP_N; i++) begin
      m = m + t;
      t = t * p10;
    end
    return m;
  endfunction

  logic [2:0]                 r_state;
  logic [DATA_WIDTH-1:0]      r_n;      // latched upper bound
  logic [DATA_WIDTH-1:0]      r_d;      // digit count of r_n
  logic [DATA_WIDTH-1:0]      r_k;      // current block length
  logic [DATA_WIDTH-1:0]      r_div;    // remaining divide-by-10 steps
  logic [DATA_WIDTH-1:0]      r_top;    // leading digits of r_n
  logic [LONG_DATA_WIDTH-1:0] r_p;      // 10^(k-1)
  logic [LONG_DATA_WIDTH-1:0] r_count;
  logic                       r_busy;
  logic                       r_done;

  logic [LONG_DATA_WIDTH-1:0] w_p10;
  logic [LONG_DATA_WIDTH-1:0] w_m;
  logic [DATA_WIDTH-1:0]      w_len;
  logic [LONG_DATA_WIDTH-1:0] w_top;
  logic [LONG_DATA_WIDTH-1:0] w_rep_top;
  logic                       w_fits;
  logic [LONG_DATA_WIDTH-1:0] w_trunc_cnt;

  assign w_p10       = r_p * LONG_DATA_WIDTH'(10);
  assign w_m         = rep_mult(w_p10);
  assign w_len       = r_k * DATA_WIDTH'(GROUP_N);
  assign w_top       = LONG_DATA_WIDTH'(r_top);
  assign w_rep_top   = w_top * w_m;
  // The top block only counts if its full repetition does not exceed n.
  assign w_fits      = (w_rep_top <= LONG_DATA_WIDTH'(r_n));
  assign w_trunc_cnt = w_top - r_p + (w_fits ? LONG_DATA_WIDTH'(1) : LONG_DATA_WIDTH'(0));

  assign digs_out  = get_digs(n_in);
  assign busy      = r_busy;
  assign done      = r_done;
  assign count_out = r_count;

`ifdef SUM_OUT_EN
  logic [LONG_DATA_WIDTH-1:0] r_sum;
  logic [LONG_DATA_WIDTH-1:0] w_top_last;
  logic [LONG_DATA_WIDTH-1:0] w_full_sum;
  logic [LONG_DATA_WIDTH-1:0] w_part_sum;

  // Arithmetic series over the blocks: (first+last)*count is always even.
  assign w_top_last = w_fits ? w_top : (w_top - LONG_DATA_WIDTH'(1));
  assign w_full_sum = (w_m * (r_p + w_p10 - LONG_DATA_WIDTH'(1))
                      * (LONG_DATA_WIDTH'(9) * r_p)) / LONG_DATA_WIDTH'(2);
  assign w_part_sum = (w_m * (r_p + w_top_last)
                      * (w_top_last - r_p + LONG_DATA_WIDTH'(1))) / LONG_DATA_WIDTH'(2);
  assign sum_out    = r_sum;

  // Sum accumulator tracks the count accumulator state for state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sum <= '0;
    end else begin
      case (r_state)
        S_LOAD:  r_sum <= '0;
        S_BLOCK: if (w_len < r_d) r_sum <= r_sum + w_full_sum;
        S_TRUNC: if (r_div == '0) r_sum <= r_sum + w_part_sum;
        default: r_sum <= r_sum;
      endcase
    end
  end
`endif

  // Control FSM and count datapath: full blocks first, then the truncated one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_n     <= '0;
      r_d     <= '0;
      r_k     <= '0;
      r_div   <= '0;
      r_top   <= '0;
      r_p     <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n     <= n_in;
            r_d     <= digs_out;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_k     <= DATA_WIDTH'(1);
          r_p     <= LONG_DATA_WIDTH'(1);
          r_count <= '0;
          r_state <= S_BLOCK;
        end
        S_BLOCK: begin
          if (w_len < r_d) begin
            r_count <= r_count + LONG_DATA_WIDTH'(9) * r_p;
            r_k     <= r_k + DATA_WIDTH'(1);
            r_p     <= w_p10;
          end else if (w_len == r_d) begin
            r_top   <= r_n;
            r_div   <= r_d - r_k;
            r_state <= S_TRUNC;
          end else begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FINAL;
          end
        end
        S_TRUNC: begin
          if (r_div != '0) begin
            r_top <= r_top / DATA_WIDTH'(10);
            r_div <= r_div - DATA_WIDTH'(1);
          end else begin
            r_count <= r_count + w_trunc_cnt;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FINAL;
          end
        end
        S_FINAL: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_digit_group_count.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for digit_group_count: directed corner cases plus random bounds,
// checked against a brute-force enumeration of repeated-block integers.
module tb_digit_group_count;

  localparam int DW = 32;
  localparam int LW = 64;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] n_in2, n_in3;
  logic          start2, start3;
  logic [DW-1:0] digs2, digs3;
  logic          busy2, busy3, done2, done3;
  logic [LW-1:0] count2, count3;
`ifdef SUM_OUT_EN
  logic [LW-1:0] sum2, sum3;
`endif

  int n_eval = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  digit_group_count #(.DATA_WIDTH(DW), .LONG_DATA_WIDTH(LW), .GROUP_N(2)) dut2 (
    .clock(clock), .reset(reset), .n_in(n_in2), .digs_out(digs2),
    .start(start2), .busy(busy2), .done(done2), .count_out(count2)
`ifdef SUM_OUT_EN
    , .sum_out(sum2)
`endif
  );

  digit_group_count #(.DATA_WIDTH(DW), .LONG_DATA_WIDTH(LW), .GROUP_N(3)) dut3 (
    .clock(clock), .reset(reset), .n_in(n_in3), .digs_out(digs3),
    .start(start3), .busy(busy3), .done(done3), .count_out(count3)
`ifdef SUM_OUT_EN
    , .sum_out(sum3)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Enumerate every block b of every length k, build its G-fold repetition
  // arithmetically and keep the ones not above n.
  function automatic void ref_model(input longint unsigned n, input int g,
                                    output longint unsigned cnt, output longint unsigned sum);
    longint unsigned pk, v;
    cnt = 0;
    sum = 0;
    pk  = 10;
    for (int k = 1; k * g <= 10; k++) begin
      for (longint unsigned b = pk / 10; b < pk; b++) begin
        v = 0;
        for (int r = 0; r < g; r++) v = v * pk + b;
        if (v > n) break;
        cnt++;
        sum += v;
      end
      pk *= 10;
    end
  endfunction

  function automatic int ref_digs(input longint unsigned n);
    string s;
    s = $sformatf("%0d", n);
    return s.len();
  endfunction

  task automatic run(input bit g3, input logic [31:0] n, input string tag);
    longint unsigned ec, es;
    bit seen;
    ref_model(longint'(n), g3 ? 3 : 2, ec, es);
    @(negedge clock);
    if (g3) n_in3 = n; else n_in2 = n;
    #1;
    check({tag, ".digs"}, g3 ? digs3 : digs2, 64'(ref_digs(longint'(n))));
    if (g3) start3 = 1'b1; else start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    start3 = 1'b0;
    check({tag, ".busy"}, g3 ? busy3 : busy2, 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 2 * DW + 4; i++) begin
      if ((g3 ? done3 : done2) === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check({tag, ".done"}, 64'(seen), 64'd1);
    check({tag, ".busy_at_done"}, g3 ? busy3 : busy2, 64'd0);
    check({tag, ".count"}, g3 ? count3 : count2, ec);
`ifdef SUM_OUT_EN
    check({tag, ".sum"}, g3 ? sum3 : sum2, es);
`endif
    @(negedge clock);
    check({tag, ".done_pulse"}, g3 ? done3 : done2, 64'd0);
    check({tag, ".count_hold"}, g3 ? count3 : count2, ec);
  endtask

  initial begin
    longint unsigned ec, es;
    int pulses;
    logic [LW-1:0] cap;
    logic [31:0] rn;

    n_in2  = '0;
    n_in3  = '0;
    start2 = 1'b0;
    start3 = 1'b0;
    reset  = 1'b0;
    repeat (3) @(negedge clock);
    check("rst.busy", busy2, 64'd0);
    check("rst.done", done2, 64'd0);
    check("rst.count", count2, 64'd0);
`ifdef SUM_OUT_EN
    check("rst.sum", sum2, 64'd0);
`endif
    reset = 1'b1;

    // Directed values with hand-derived results
    run(1'b0, 32'd102, "n102");
    check("n102.count_const", count2, 64'd9);
`ifdef SUM_OUT_EN
    check("n102.sum_const", sum2, 64'd495);
`endif
    run(1'b0, 32'd1212, "n1212");
    check("n1212.count_const", count2, 64'd12);
    run(1'b0, 32'd1211, "n1211");
    check("n1211.count_const", count2, 64'd11);
    run(1'b0, 32'd0, "n0");
    check("n0.count_const", count2, 64'd0);
    run(1'b0, 32'd9, "n9");
    run(1'b0, 32'd11, "n11");
    check("n11.count_const", count2, 64'd1);
    run(1'b0, 32'd4294967295, "nmax");
    run(1'b1, 32'd1000, "g3_n1000");
    check("g3_n1000.count_const", count3, 64'd9);
`ifdef SUM_OUT_EN
    check("g3_n1000.sum_const", sum3, 64'd4995);
`endif

    // Random bounds over the full range and a small range
    for (int i = 0; i < 6; i++) begin
      rn = $urandom();
      run(1'b0, rn, $sformatf("rnd_big%0d", i));
    end
    for (int i = 0; i < 6; i++) begin
      rn = 32'($urandom_range(0, 99999));
      run(1'b0, rn, $sformatf("rnd_small%0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      rn = $urandom();
      run(1'b1, rn, $sformatf("g3_rnd%0d", i));
    end

    // Reset asserted mid-count clears everything without a clock edge
    @(negedge clock);
    n_in2  = 32'd4000000000;
    start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst.busy", busy2, 64'd0);
    check("midrst.done", done2, 64'd0);
    check("midrst.count", count2, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    run(1'b0, 32'd1212, "after_rst");

    // Second start while busy must be ignored
    ref_model(64'd4000000000, 2, ec, es);
    @(negedge clock);
    n_in2  = 32'd4000000000;
    start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    @(negedge clock);
    n_in2  = 32'd99;
    start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    pulses = 0;
    cap    = '0;
    for (int i = 0; i < 40; i++) begin
      if (done2 === 1'b1) begin
        pulses++;
        if (pulses == 1) cap = count2;
      end
      @(negedge clock);
    end
    check("busy_start.pulses", 64'(pulses), 64'd1);
    check("busy_start.count", cap, ec);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
